// File: rtl/spi_fsm.sv
// spi_fsm: slave-side SPI transaction sequencer driving address latch, data memory, shift-register load and MISO enables
module spi_fsm #(
   parameter int width = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic cs,
   input  logic sclkPosEdge,
   input  logic sclkNegEdge,
   input  logic rwBit,
   output logic addrWE,
   output logic dmWE,
   output logic srLoad,
   output logic misoBufe,
   output logic busy
);
   localparam int CW = $clog2(width) + 1;
   localparam logic [CW-1:0] LAST = CW'(width - 1);
   typedef enum logic [3:0] {
      IDLE, GET_ADDR, GOT_ADDR, READ_WAIT, READ_LOAD, READ_SHIFT, WRITE_SHIFT, WRITE_MEM, DONE
   } state_t;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            cnt_d   = '0;
            state_d = cs ? IDLE : GET_ADDR;
         end
         GET_ADDR: if (sclkPosEdge) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == LAST) ? GOT_ADDR : GET_ADDR;
         end
         GOT_ADDR: begin
            cnt_d   = '0;
            state_d = rwBit ? READ_WAIT : WRITE_SHIFT;
         end
         READ_WAIT: state_d = READ_LOAD;
         READ_LOAD: state_d = READ_SHIFT;
         READ_SHIFT: if (sclkNegEdge) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == LAST) ? DONE : READ_SHIFT;
         end
         WRITE_SHIFT: if (sclkPosEdge) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == LAST) ? WRITE_MEM : WRITE_SHIFT;
         end
         WRITE_MEM: state_d = DONE;
         DONE: state_d = cs ? IDLE : DONE;
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      // chip-select release beats any edge pulse or terminal count
      if (cs && state_q != IDLE) begin
         state_d = IDLE;
         cnt_d   = '0;
      end
   end
   assign addrWE   = (state_q == GOT_ADDR);
   assign dmWE     = (state_q == WRITE_MEM);
   assign srLoad   = (state_q == READ_LOAD);
   assign misoBufe = (state_q == READ_SHIFT);
   assign busy     = (state_q != IDLE);
endmodule

// File: tb/tb_spi_fsm.sv
// tb_spi_fsm: directed checks of the SPI transaction sequencer
module tb_spi_fsm;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic cs = 1'b1;
   logic sclkPosEdge = 1'b0;
   logic sclkNegEdge = 1'b0;
   logic rwBit = 1'b0;
   logic addrWE, dmWE, srLoad, misoBufe, busy;
   int checks = 0;
   int errors = 0;
   int n_addr = 0, n_dm = 0, n_ld = 0, n_miso = 0;
   int s_addr, s_dm, s_ld, s_miso;
   spi_fsm #(.width(8)) dut (
      .clk(clk), .reset(reset), .cs(cs), .sclkPosEdge(sclkPosEdge), .sclkNegEdge(sclkNegEdge),
      .rwBit(rwBit), .addrWE(addrWE), .dmWE(dmWE), .srLoad(srLoad), .misoBufe(misoBufe), .busy(busy)
   );
   always #5 clk = ~clk;
   always @(negedge clk) begin
      n_addr += int'(addrWE);
      n_dm   += int'(dmWE);
      n_ld   += int'(srLoad);
      n_miso += int'(misoBufe);
   end
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic send_pos(input int n);
      for (int i = 0; i < n; i++) begin
         sclkPosEdge = 1'b1;
         cyc();
         sclkPosEdge = 1'b0;
         if (i != n - 1) cyc();
      end
   endtask
   task automatic send_neg(input int n);
      for (int i = 0; i < n; i++) begin
         sclkNegEdge = 1'b1;
         cyc();
         sclkNegEdge = 1'b0;
         if (i != n - 1) cyc();
      end
   endtask
   task automatic snap();
      s_addr = n_addr; s_dm = n_dm; s_ld = n_ld; s_miso = n_miso;
   endtask
   task automatic test_reset();
      cs = 1'b0;
      cyc(); cyc();
      checks++; if ({addrWE, dmWE, srLoad, misoBufe, busy} !== 5'b0) begin errors++; $display("FAIL reset_outs got %b exp 00000", {addrWE, dmWE, srLoad, misoBufe, busy}); end
      cs = 1'b1;
      reset = 1'b0;
      cyc();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle busy got %b exp 0", busy); end
   endtask
   task automatic test_read();
      snap();
      cs = 1'b0; rwBit = 1'b1;
      cyc();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rd_busy got %b exp 1", busy); end
      send_pos(7);
      checks++; if (addrWE !== 1'b0) begin errors++; $display("FAIL rd_addr7 got %b exp 0", addrWE); end
      send_pos(1);
      checks++; if (addrWE !== 1'b1) begin errors++; $display("FAIL rd_addr8 got %b exp 1", addrWE); end
      cyc();
      checks++; if ({addrWE, srLoad, misoBufe, busy} !== 4'b0001) begin errors++; $display("FAIL rd_wait got %b exp 0001", {addrWE, srLoad, misoBufe, busy}); end
      cyc();
      checks++; if ({srLoad, misoBufe} !== 2'b10) begin errors++; $display("FAIL rd_load got %b exp 10", {srLoad, misoBufe}); end
      cyc();
      checks++; if ({srLoad, misoBufe} !== 2'b01) begin errors++; $display("FAIL rd_shift got %b exp 01", {srLoad, misoBufe}); end
      send_neg(7);
      checks++; if (misoBufe !== 1'b1) begin errors++; $display("FAIL rd_miso7 got %b exp 1", misoBufe); end
      send_neg(1);
      checks++; if ({misoBufe, busy} !== 2'b01) begin errors++; $display("FAIL rd_done got %b exp 01", {misoBufe, busy}); end
      send_pos(2); send_neg(2);
      checks++; if ({addrWE, dmWE, srLoad, misoBufe, busy} !== 5'b00001) begin errors++; $display("FAIL rd_done_hold got %b exp 00001", {addrWE, dmWE, srLoad, misoBufe, busy}); end
      checks++; if ({n_addr - s_addr, n_ld - s_ld, n_dm - s_dm} !== {32'd1, 32'd1, 32'd0}) begin errors++; $display("FAIL rd_counts got addr %0d ld %0d dm %0d exp 1 1 0", n_addr - s_addr, n_ld - s_ld, n_dm - s_dm); end
      cs = 1'b1;
      cyc();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_release got %b exp 0", busy); end
   endtask
   task automatic test_write();
      snap();
      cs = 1'b0; rwBit = 1'b0;
      cyc();
      send_pos(8);
      checks++; if (addrWE !== 1'b1) begin errors++; $display("FAIL wr_addr got %b exp 1", addrWE); end
      cyc();
      checks++; if ({addrWE, dmWE, srLoad, misoBufe, busy} !== 5'b00001) begin errors++; $display("FAIL wr_shift got %b exp 00001", {addrWE, dmWE, srLoad, misoBufe, busy}); end
      send_pos(7);
      checks++; if (dmWE !== 1'b0) begin errors++; $display("FAIL wr_dm15 got %b exp 0", dmWE); end
      send_pos(1);
      checks++; if (dmWE !== 1'b1) begin errors++; $display("FAIL wr_dm16 got %b exp 1", dmWE); end
      cyc();
      checks++; if ({dmWE, busy} !== 2'b01) begin errors++; $display("FAIL wr_done got %b exp 01", {dmWE, busy}); end
      checks++; if ({n_dm - s_dm, n_ld - s_ld, n_miso - s_miso} !== {32'd1, 32'd0, 32'd0}) begin errors++; $display("FAIL wr_counts got dm %0d ld %0d miso %0d exp 1 0 0", n_dm - s_dm, n_ld - s_ld, n_miso - s_miso); end
      cs = 1'b1;
      cyc();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_release got %b exp 0", busy); end
   endtask
   task automatic test_abort_write();
      snap();
      cs = 1'b0; rwBit = 1'b0;
      cyc();
      send_pos(8);
      cyc();
      send_pos(5);
      cs = 1'b1;
      cyc();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ab_idle got %b exp 0", busy); end
      send_pos(3);
      checks++; if (n_dm - s_dm !== 0) begin errors++; $display("FAIL ab_dm got %0d exp 0", n_dm - s_dm); end
      cs = 1'b0;
      cyc();
      send_pos(7);
      checks++; if (addrWE !== 1'b0) begin errors++; $display("FAIL ab_re7 got %b exp 0", addrWE); end
      send_pos(1);
      checks++; if (addrWE !== 1'b1) begin errors++; $display("FAIL ab_re8 got %b exp 1", addrWE); end
      cs = 1'b1;
      cyc();
      checks++; if ({addrWE, busy} !== 2'b00) begin errors++; $display("FAIL ab_got_abort got %b exp 00", {addrWE, busy}); end
   endtask
   task automatic test_collision();
      snap();
      cs = 1'b0; rwBit = 1'b1;
      cyc();
      send_pos(7);
      cyc();
      sclkPosEdge = 1'b1; cs = 1'b1;
      cyc();
      sclkPosEdge = 1'b0;
      checks++; if ({addrWE, busy} !== 2'b00) begin errors++; $display("FAIL col_idle got %b exp 00", {addrWE, busy}); end
      cyc();
      checks++; if (n_addr - s_addr !== 0) begin errors++; $display("FAIL col_addr got %0d exp 0", n_addr - s_addr); end
   endtask
   task automatic test_reset_read();
      cs = 1'b0; rwBit = 1'b1;
      cyc();
      send_pos(8);
      cyc(); cyc(); cyc();
      checks++; if (misoBufe !== 1'b1) begin errors++; $display("FAIL rr_shift got %b exp 1", misoBufe); end
      send_neg(3);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      checks++; if ({addrWE, dmWE, srLoad, misoBufe, busy} !== 5'b0) begin errors++; $display("FAIL rr_outs got %b exp 00000", {addrWE, dmWE, srLoad, misoBufe, busy}); end
      cyc();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rr_get got %b exp 1", busy); end
      send_pos(7);
      checks++; if (addrWE !== 1'b0) begin errors++; $display("FAIL rr_addr7 got %b exp 0", addrWE); end
      send_pos(1);
      checks++; if (addrWE !== 1'b1) begin errors++; $display("FAIL rr_addr8 got %b exp 1", addrWE); end
      cs = 1'b1;
      cyc();
   endtask
   task automatic test_spurious();
      cs = 1'b0; rwBit = 1'b1;
      cyc();
      for (int i = 0; i < 8; i++) begin
         sclkNegEdge = 1'b1;
         cyc();
         sclkNegEdge = i[0];
         sclkPosEdge = 1'b1;
         cyc();
         sclkNegEdge = 1'b0; sclkPosEdge = 1'b0;
         checks++; if (addrWE !== (i == 7)) begin errors++; $display("FAIL sp_addr%0d got %b exp %b", i, addrWE, i == 7); end
      end
      cyc(); cyc(); cyc();
      send_pos(5);
      checks++; if (misoBufe !== 1'b1) begin errors++; $display("FAIL sp_miso_pos got %b exp 1", misoBufe); end
      send_neg(7);
      checks++; if (misoBufe !== 1'b1) begin errors++; $display("FAIL sp_miso7 got %b exp 1", misoBufe); end
      sclkPosEdge = 1'b1;
      send_neg(1);
      sclkPosEdge = 1'b0;
      checks++; if ({misoBufe, busy} !== 2'b01) begin errors++; $display("FAIL sp_done got %b exp 01", {misoBufe, busy}); end
      cs = 1'b1;
      cyc();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sp_release got %b exp 0", busy); end
   endtask
   initial begin
      test_reset();
      test_read();
      test_write();
      test_abort_write();
      test_collision();
      test_reset_read();
      test_spurious();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
